bcd_to_binary: RTL and testbench

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

---
 rtl/stopwatch_pkg.sv | 6 +
 rtl/bcd_digit_valid.sv | 9 +
 rtl/bcd_to_binary.sv | 92 +++++++++
 tb/tb_bcd_to_binary.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM encoding and BCD digit constants
package stopwatch_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CONV, ST_DONE} state_t;
endpackage

// File: rtl/bcd_digit_valid.sv
// bcd_digit_valid: flags a 4-bit digit as a legal decimal digit (0..9)
module bcd_digit_valid
  import stopwatch_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic               valid
);
  assign valid = digit <= DIGIT_MAX;
endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: multi-cycle BCD to binary converter, one digit per cycle MSD first
module bcd_to_binary
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       thousands_in,
  input  logic [3:0]       hundreds_in,
  input  logic [3:0]       tens_in,
  input  logic [3:0]       ones_in,
  output logic [BIN_W-1:0] bin_out,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int SR_W  = N_DIGITS * DIGIT_W;
  localparam int ACC_W = BIN_W + 3;
  localparam int CNT_W = $clog2(N_DIGITS + 1);

  state_t              state, next_state;
  logic [SR_W-1:0]     dig_sr;
  logic [ACC_W-1:0]    acc, acc_next;
  logic [CNT_W-1:0]    cnt;
  logic [N_DIGITS-1:0] digit_ok;
  logic [DIGIT_W-1:0]  cur_digit;
  logic [4*DIGIT_W-1:0] digits_in;
  logic                all_valid, last;

  assign digits_in = {thousands_in, hundreds_in, tens_in, ones_in};
  assign cur_digit = dig_sr[SR_W-1 -: DIGIT_W];
  assign acc_next  = (acc << 3) + (acc << 1) + ACC_W'(cur_digit);
  assign all_valid = &digit_ok;
  assign last      = cnt == CNT_W'(N_DIGITS - 1);

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_valid
    bcd_digit_valid u_valid (
      .digit(dig_sr[g*DIGIT_W +: DIGIT_W]),
      .valid(digit_ok[g])
    );
  end

  // state register
  always_ff @(posedge clk) begin
    state <= rst ? ST_IDLE : next_state;
  end

  // next-state and busy decode; start only matters in IDLE
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    next_state = (state == ST_IDLE) ? (start ? ST_LOAD : ST_IDLE) :
                 (state == ST_LOAD) ? (all_valid ? ST_CONV : ST_DONE) :
                 (state == ST_CONV) ? (last ? ST_DONE : ST_CONV) : ST_IDLE;
    busy       = state == ST_LOAD || state == ST_CONV;
  end

  // datapath: capture, validate, shift-and-add accumulate; results change only entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_sr  <= '0;
      acc     <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= state == ST_DONE;
      if (state == ST_IDLE && start) dig_sr <= SR_W'(digits_in);
      if (state == ST_LOAD && all_valid) begin
        acc <= '0;
        cnt <= '0;
      end
      if (state == ST_LOAD && !all_valid) begin
        err     <= 1'b1;
        bin_out <= '0;
      end
      if (state == ST_CONV) begin
        acc    <= acc_next;
        dig_sr <= dig_sr << DIGIT_W;
        cnt    <= cnt + CNT_W'(1);
      end
      if (state == ST_CONV && last) begin
        bin_out <= acc_next[BIN_W-1:0];
        err     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: table-driven and scoreboard checks of bcd_to_binary
module tb_bcd_to_binary;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  th, hu, te, on;
  logic [13:0] bin_out;
  logic        busy, done, err;

  typedef struct {
    logic [3:0]  th, hu, te, on;
    logic [13:0] bin;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [13:0] bin;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   failures = 0;

  bcd_to_binary dut (
    .clk(clk), .rst(rst), .start(start),
    .thousands_in(th), .hundreds_in(hu), .tens_in(te), .ones_in(on),
    .bin_out(bin_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // advance one cycle, sample #1 after the edge, and score any completion
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        e = sb.pop_front();
        check("result_bin", int'(bin_out), int'(e.bin));
        check("result_err", int'(err), int'(e.err));
      end
    end
  endtask

  task automatic drive(input logic [3:0] a, b, c, d);
    th = a; hu = b; te = c; on = d; start = 1'b1;
  endtask

  task automatic scramble();
    th = 4'($urandom); hu = 4'($urandom); te = 4'($urandom); on = 4'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    int lat = 0;
    drive(v.th, v.hu, v.te, v.on);
    sb.push_back('{err: v.err, bin: v.bin});
    tick();
    start = 1'b0;
    scramble();
    check("busy_in_load", int'(busy), 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, v.err ? 2 : 6);
    tick();
    check("done_single_pulse", int'(done), 0);
  endtask

  initial begin
    int k, ndone;
    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 14'd1234, 1'b0};
    vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 14'd9999, 1'b0};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 14'd0,    1'b0};
    vecs[3] = '{4'd0, 4'd10, 4'd0, 4'd0, 14'd0,   1'b1};
    vecs[4] = '{4'd0, 4'd0, 4'd5, 4'd9, 14'd59,   1'b0};
    vecs[5] = '{4'd9, 4'd0, 4'd0, 4'd1, 14'd9001, 1'b0};
    vecs[6] = '{4'd3, 4'd1, 4'd4, 4'd15, 14'd0,   1'b1};
    vecs[7] = '{4'd8, 4'd7, 4'd6, 4'd5, 14'd8765, 1'b0};
    vecs[8] = '{4'd10, 4'd0, 4'd0, 4'd0, 14'd0,   1'b1};
    vecs[9] = '{4'd0, 4'd3, 4'd6, 4'd0, 14'd360,  1'b0};
    rst = 1'b1; start = 1'b0; th = 0; hu = 0; te = 0; on = 0;
    tick(); tick(); tick();
    rst = 1'b0;
    check("reset_bin", int'(bin_out), 0);
    check("reset_err", int'(err), 0);
    check("reset_done", int'(done), 0);
    check("reset_busy", int'(busy), 0);

    rst = 1'b1;
    drive(4'd1, 4'd1, 4'd1, 4'd1);
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_over_start_busy", int'(busy), 0);
    tick();
    check("idle_after_rst_busy", int'(busy), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // start re-pulsed during CONV with other digits must be ignored
    drive(4'd1, 4'd2, 4'd3, 4'd4);
    sb.push_back('{err: 1'b0, bin: 14'd1234});
    tick();
    start = 1'b0;
    tick(); tick();
    drive(4'd5, 4'd6, 4'd7, 4'd8);
    tick();
    start = 1'b0;
    k = 3;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("repulse_latency", k, 6);
    for (int i = 0; i < 10; i++) tick();

    // reset in the third CONV cycle aborts without a done pulse
    drive(4'd9, 4'd8, 4'd7, 4'd6);
    tick();
    start = 1'b0;
    scramble();
    tick(); tick(); tick();
    check("pre_abort_bin", int'(bin_out), 1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_bin", int'(bin_out), 0);
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    for (int i = 0; i < 10; i++) tick();
    run_vec('{4'd0, 4'd4, 4'd2, 4'd0, 14'd420, 1'b0});

    // start held high: one conversion every 7 cycles
    drive(4'd0, 4'd3, 4'd6, 4'd0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 7 == 0) sb.push_back('{err: 1'b0, bin: 14'd360});
      tick();
      if (done === 1'b1) begin
        ndone++;
        check("stream_phase", i % 7, 6);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("stream_done_count", ndone, 5);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
